// File: rtl/uart_resp_tx.sv
// Response path of the UART debugger: formats one command result as ASCII
// (hex byte, "OK" or "?", each ended by CR LF) and serialises it as 8N1 frames.
module uart_resp_tx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_resp_valid,
  output logic       o_resp_ready,
  input  logic [1:0] i_resp_kind,
  input  logic [7:0] i_resp_data,
  output logic       o_uart_tx_pin,
  output logic       o_busy
);
  localparam int BAUD_TICK = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W = (BAUD_TICK > 1) ? $clog2(BAUD_TICK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_TICK - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [1:0]       char_idx;
  logic [1:0]       last_idx;
  logic [1:0]       kind;
  logic [7:0]       data;
  logic [7:0]       cur_char;
  logic             bit_end;

  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  // Character currently being shifted out, selected from the latched response.
  always_comb begin
    cur_char = 8'h0A;
    case (kind)
      2'b00: case (char_idx)
        2'd0:    cur_char = hex(data[7:4]);
        2'd1:    cur_char = hex(data[3:0]);
        2'd2:    cur_char = 8'h0D;
        default: cur_char = 8'h0A;
      endcase
      2'b01: case (char_idx)
        2'd0:    cur_char = 8'h4F;
        2'd1:    cur_char = 8'h4B;
        2'd2:    cur_char = 8'h0D;
        default: cur_char = 8'h0A;
      endcase
      default: case (char_idx)
        2'd0:    cur_char = 8'h3F;
        2'd1:    cur_char = 8'h0D;
        default: cur_char = 8'h0A;
      endcase
    endcase
  end

  assign bit_end = (baud_cnt == CNT_LAST);

  // The pin register follows the state one clock behind, so every bit is
  // exactly BAUD_TICK clocks wide and the start bit appears one edge after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      baud_cnt      <= '0;
      bit_idx       <= '0;
      char_idx      <= '0;
      last_idx      <= '0;
      kind          <= '0;
      data          <= '0;
      o_uart_tx_pin <= 1'b1;
      o_resp_ready  <= 1'b1;
      o_busy        <= 1'b0;
    end else begin
      case (state)
        START:   o_uart_tx_pin <= 1'b0;
        DATA:    o_uart_tx_pin <= cur_char[bit_idx];
        default: o_uart_tx_pin <= 1'b1;
      endcase

      case (state)
        IDLE: if (i_resp_valid) begin
          kind         <= i_resp_kind;
          data         <= i_resp_data;
          last_idx     <= i_resp_kind[1] ? 2'd2 : 2'd3;
          char_idx     <= '0;
          bit_idx      <= '0;
          baud_cnt     <= '0;
          state        <= START;
          o_resp_ready <= 1'b0;
          o_busy       <= 1'b1;
        end
        START: if (bit_end) begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          state    <= DATA;
        end else baud_cnt <= baud_cnt + CNT_W'(1);
        DATA: if (bit_end) begin
          baud_cnt <= '0;
          if (bit_idx == 3'd7) state <= STOP;
          else bit_idx <= bit_idx + 3'd1;
        end else baud_cnt <= baud_cnt + CNT_W'(1);
        STOP: if (bit_end) begin
          baud_cnt <= '0;
          if (char_idx == last_idx) begin
            char_idx     <= '0;
            state        <= IDLE;
            o_resp_ready <= 1'b1;
            o_busy       <= 1'b0;
          end else begin
            char_idx <= char_idx + 2'd1;
            state    <= START;
          end
        end else baud_cnt <= baud_cnt + CNT_W'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_resp_tx.sv
// Bench for uart_resp_tx: a bit-accurate UART receiver model plus directed
// vectors for message content, latency, back-to-back, held valid and reset abort.
module tb_uart_resp_tx;
  localparam int CLK_FREQ  = 1600000;
  localparam int BAUD_RATE = 100000;
  localparam int BT        = 16;
  localparam int FRAME     = 10 * BT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       resp_valid = 1'b0;
  logic [1:0] resp_kind  = 2'b00;
  logic [7:0] resp_data  = 8'h00;
  logic       resp_ready, uart_tx_pin, busy;

  uart_resp_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .rst_n(rst_n), .i_resp_valid(resp_valid), .o_resp_ready(resp_ready),
    .i_resp_kind(resp_kind), .i_resp_data(resp_data), .o_uart_tx_pin(uart_tx_pin),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Receiver: samples mid-bit, and flags any pin edge not on a bit boundary.
  logic [7:0] rx_q[$];
  int         st_q[$];
  logic       stop_q[$];
  int         misaligned = 0;
  initial begin
    logic [7:0] d;
    logic       last, stp, abort;
    int         fs;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && uart_tx_pin === 1'b0) begin
        fs = cyc; d = '0; last = 1'b0; stp = 1'b0; abort = 1'b0;
        for (int k = 1; k < FRAME; k++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin abort = 1'b1; break; end
          if (uart_tx_pin !== last) begin
            if (k % BT != 0) misaligned++;
            last = uart_tx_pin;
          end
          if (k % BT == BT / 2) begin
            if (k / BT >= 1 && k / BT <= 8) d[k/BT-1] = uart_tx_pin;
            else if (k / BT == 9) stp = uart_tx_pin;
          end
        end
        if (!abort) begin rx_q.push_back(d); st_q.push_back(fs); stop_q.push_back(stp); end
      end
    end
  end

  task automatic clear_q();
    rx_q.delete(); st_q.delete(); stop_q.delete();
  endtask

  task automatic send(input logic [1:0] k, input logic [7:0] d, output int acc);
    int t = 0;
    @(negedge clk);
    while (resp_ready !== 1'b1 && t < 100 * FRAME) begin @(negedge clk); t++; end
    chk("send_ready", int'(resp_ready), 1);
    resp_valid = 1'b1; resp_kind = k; resp_data = d;
    @(posedge clk); #1;
    acc = cyc;
    resp_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input string name);
    int t = 0;
    while (rx_q.size() < n && t < 100 * FRAME) begin @(negedge clk); t++; end
    chk({name, "_frames"}, int'(rx_q.size() >= n), 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 100 * FRAME) begin @(negedge clk); t++; end
    chk("wait_idle", int'(busy), 0);
  endtask

  // msg holds the expected characters, first one in the top byte
  typedef struct {
    logic [1:0]  kind;
    logic [7:0]  data;
    int          n;
    logic [31:0] msg;
  } vec_t;

  vec_t tbl[7];
  int   acc, acc2, dur, t;

  initial begin
    tbl[0] = '{kind: 2'b00, data: 8'hAA, n: 4, msg: 32'h41410D0A};
    tbl[1] = '{kind: 2'b00, data: 8'h09, n: 4, msg: 32'h30390D0A};
    tbl[2] = '{kind: 2'b00, data: 8'hF0, n: 4, msg: 32'h46300D0A};
    tbl[3] = '{kind: 2'b01, data: 8'h55, n: 4, msg: 32'h4F4B0D0A};
    tbl[4] = '{kind: 2'b10, data: 8'h00, n: 3, msg: 32'h3F0D0A00};
    tbl[5] = '{kind: 2'b11, data: 8'hFF, n: 3, msg: 32'h3F0D0A00};
    tbl[6] = '{kind: 2'b00, data: 8'h5B, n: 4, msg: 32'h35420D0A};

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_pin", int'(uart_tx_pin), 1);
    chk("rst_ready", int'(resp_ready), 1);
    chk("rst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Accept timing and message duration
    clear_q();
    @(negedge clk);
    resp_valid = 1'b1; resp_kind = 2'b00; resp_data = 8'hAA;
    @(posedge clk); #1;
    acc = cyc;
    resp_valid = 1'b0;
    chk("acc_ready", int'(resp_ready), 0);
    chk("acc_busy", int'(busy), 1);
    chk("acc_pin", int'(uart_tx_pin), 1);
    @(posedge clk); #1;
    chk("lat_pin", int'(uart_tx_pin), 0);
    t = 0;
    while (busy === 1'b1 && t < 100 * FRAME) begin @(posedge clk); #1; t++; end
    dur = cyc - acc;
    chk("msg_duration", dur, 4 * FRAME);
    chk("end_ready", int'(resp_ready), 1);
    wait_frames(4, "t1");
    chk("t1_last_byte", int'(rx_q[3]), 8'h0A);

    // Content vectors
    for (int i = 0; i < 7; i++) begin
      clear_q();
      send(tbl[i].kind, tbl[i].data, acc);
      wait_frames(tbl[i].n, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_latency", i), st_q[0], acc + 1);
      for (int j = 0; j < tbl[i].n; j++) begin
        chk($sformatf("vec%0d_ch%0d", i, j), int'(rx_q[j]), int'(tbl[i].msg[31-8*j -: 8]));
        chk($sformatf("vec%0d_stop%0d", i, j), int'(stop_q[j]), 1);
        if (j > 0) chk($sformatf("vec%0d_gap%0d", i, j), st_q[j] - st_q[j-1], FRAME);
      end
      wait_idle();
      repeat (FRAME) @(negedge clk);
      chk($sformatf("vec%0d_count", i), rx_q.size(), tbl[i].n);
    end

    // Back-to-back: second accepted in the first idle cycle
    clear_q();
    send(2'b00, 8'h09, acc);
    send(2'b00, 8'hF0, acc2);
    wait_frames(8, "b2b");
    chk("b2b_m1c0", int'(rx_q[0]), 8'h30);
    chk("b2b_m1c1", int'(rx_q[1]), 8'h39);
    chk("b2b_m2c0", int'(rx_q[4]), 8'h46);
    chk("b2b_m2c1", int'(rx_q[5]), 8'h30);
    chk("b2b_m2c3", int'(rx_q[7]), 8'h0A);
    chk("b2b_idle_gap", st_q[4] - st_q[3], FRAME + 1);
    chk("b2b_accept", acc2 - acc, 4 * FRAME + 1);

    // Valid held with new contents mid-message
    wait_idle();
    clear_q();
    send(2'b00, 8'h3C, acc);
    repeat (2 * FRAME) @(negedge clk);
    resp_valid = 1'b1; resp_kind = 2'b01; resp_data = 8'hE7;
    @(negedge clk);
    chk("hold_ready", int'(resp_ready), 0);
    t = 0;
    while (resp_ready !== 1'b1 && t < 100 * FRAME) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    acc2 = cyc;
    resp_valid = 1'b0;
    wait_frames(8, "hold");
    chk("hold_m1c0", int'(rx_q[0]), 8'h33);
    chk("hold_m1c1", int'(rx_q[1]), 8'h43);
    chk("hold_m1c2", int'(rx_q[2]), 8'h0D);
    chk("hold_m2c0", int'(rx_q[4]), 8'h4F);
    chk("hold_m2c1", int'(rx_q[5]), 8'h4B);
    chk("hold_m2_start", st_q[4], acc2 + 1);

    // Reset in the middle of the second character's start bit
    wait_idle();
    clear_q();
    send(2'b00, 8'h12, acc);
    t = 0;
    while (cyc < acc + 1 + FRAME + BT / 2 && t < 100 * FRAME) begin @(negedge clk); t++; end
    chk("rst_mid_pin_before", int'(uart_tx_pin), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_pin", int'(uart_tx_pin), 1);
    chk("rst_mid_ready", int'(resp_ready), 1);
    chk("rst_mid_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * FRAME) @(negedge clk);
    chk("rst_mid_frames", rx_q.size(), 1);
    chk("rst_mid_char0", int'(rx_q[0]), 8'h31);
    chk("rst_mid_idle_pin", int'(uart_tx_pin), 1);
    chk("rst_mid_idle_ready", int'(resp_ready), 1);

    chk("bit_edges", misaligned, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
